// File: rtl/instruction_fetch_if.sv
// Instruction-memory request/grant/response bus between the fetch stage and imem.
// The fetch stage is the master: it drives req/addr and receives gnt/rvalid/rdata.
interface instruction_fetch_if #(
   parameter int XLEN = 32
);
   logic            req;
   logic [XLEN-1:0] addr;
   logic            gnt;
   logic            rvalid;
   logic [31:0]     rdata;

   modport master (output req, output addr, input gnt, input rvalid, input rdata);
   modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface

// File: rtl/instruction_fetch.sv
// RockWave fetch stage: PC register, one imem read per phase_fetch, redirects from
// execute (pending while a fetch is in flight) and a watchdog that aborts stuck fetches.
module instruction_fetch #(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter int              TIMEOUT      = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                phase_fetch,
   input  logic                jump_en_ex,
   input  logic [XLEN-1:0]     jump_addr_ex,
   instruction_fetch_if.master imem,
   output logic [31:0]         inst,
   output logic [XLEN-1:0]     curr_pc_fd,
   output logic [XLEN-1:0]     next_pc_fd,
   output logic                fetch_done,
   output logic                fetch_err,
   output logic                misaligned,
   output logic                stall_fetch
);
   localparam logic [31:0]     NOP  = 32'h0000_0013;
   localparam logic [XLEN-1:0] FOUR = XLEN'(4);

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   state_t          state, state_nxt;
   logic [XLEN-1:0] pc, pc_inc, pend_pc, tgt;
   logic            pend_vld;
   logic [7:0]      wdog;
   logic            wdog_exp, complete, abort;
   logic            unused_lsb;

   // JALR rule: bit 0 is dropped, bit 1 only flags misalignment
   assign tgt        = {jump_addr_ex[XLEN-1:2], 2'b00};
   assign unused_lsb = jump_addr_ex[0];
   assign pc_inc     = pc + FOUR;
   assign wdog_exp   = (wdog == 8'(TIMEOUT - 1));

   assign imem.addr   = pc;
   assign stall_fetch = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // A response arriving in the watchdog's last cycle still completes normally
   always_comb begin
      state_nxt = state;
      complete  = 1'b0;
      abort     = 1'b0;
      imem.req  = 1'b0;
      case (state)
         IDLE: begin
            if (phase_fetch) state_nxt = REQ;
         end
         REQ: begin
            imem.req = 1'b1;
            if (imem.gnt && imem.rvalid) complete  = 1'b1;
            else if (wdog_exp)           abort     = 1'b1;
            else if (imem.gnt)           state_nxt = WAIT;
         end
         WAIT: begin
            if (imem.rvalid)   complete = 1'b1;
            else if (wdog_exp) abort    = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
      if (complete || abort) state_nxt = IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc         <= RESET_VECTOR;
         pend_pc    <= '0;
         pend_vld   <= 1'b0;
         wdog       <= '0;
         inst       <= NOP;
         curr_pc_fd <= RESET_VECTOR;
         next_pc_fd <= RESET_VECTOR + FOUR;
         fetch_done <= 1'b0;
         fetch_err  <= 1'b0;
         misaligned <= 1'b0;
      end else begin
         fetch_done <= complete | abort;
         fetch_err  <= abort;
         if (jump_en_ex) misaligned <= jump_addr_ex[1];
         wdog <= (state == IDLE) ? 8'd0 : wdog + 8'd1;

         if (complete || abort) begin
            inst       <= complete ? imem.rdata : NOP;
            curr_pc_fd <= pc;
            next_pc_fd <= pc_inc;
            pend_vld   <= 1'b0;
            // Same-cycle redirect beats both the pending target and PC+4
            if (jump_en_ex)    pc <= tgt;
            else if (pend_vld) pc <= pend_pc;
            else if (complete) pc <= pc_inc;
         end else if (state == IDLE) begin
            if (jump_en_ex) begin
               if (phase_fetch) begin
                  pend_pc  <= tgt;
                  pend_vld <= 1'b1;
               end else begin
                  pc <= tgt;
               end
            end
         end else if (jump_en_ex) begin
            pend_pc  <= tgt;
            pend_vld <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed cases plus randomized fetch transactions whose
// outcome (latency, abort, final PC, outputs) is computed per transaction from the rules.
module tb_instruction_fetch;
   localparam int          TO  = 4;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst, phase_fetch, jump_en_ex;
   logic [31:0] jump_addr_ex;
   logic [31:0] inst, curr_pc_fd, next_pc_fd;
   logic        fetch_done, fetch_err, misaligned, stall_fetch;

   int total = 0;
   int bad   = 0;

   logic [31:0] m_pc, m_inst, m_cur, m_nxt;
   logic        m_mis;

   instruction_fetch_if #(.XLEN(32)) imem_bus ();

   instruction_fetch #(.XLEN(32), .RESET_VECTOR(32'h0), .TIMEOUT(TO)) dut (
      .clk          (clk),
      .rst          (rst),
      .phase_fetch  (phase_fetch),
      .jump_en_ex   (jump_en_ex),
      .jump_addr_ex (jump_addr_ex),
      .imem         (imem_bus),
      .inst         (inst),
      .curr_pc_fd   (curr_pc_fd),
      .next_pc_fd   (next_pc_fd),
      .fetch_done   (fetch_done),
      .fetch_err    (fetch_err),
      .misaligned   (misaligned),
      .stall_fetch  (stall_fetch)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clr_in;
      phase_fetch     = 1'b0;
      jump_en_ex      = 1'b0;
      jump_addr_ex    = '0;
      imem_bus.gnt    = 1'b0;
      imem_bus.rvalid = 1'b0;
      imem_bus.rdata  = '0;
   endtask

   task automatic chk_hold;
      chk("inst", inst, m_inst);
      chk("curr_pc", curr_pc_fd, m_cur);
      chk("next_pc", next_pc_fd, m_nxt);
      chk("misaligned", {31'b0, misaligned}, {31'b0, m_mis});
   endtask

   task automatic do_reset;
      clr_in();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      m_pc = 32'h0; m_inst = NOP; m_cur = 32'h0; m_nxt = 32'h4; m_mis = 1'b0;
      chk("rst_addr", imem_bus.addr, m_pc);
      chk("rst_req", {31'b0, imem_bus.req}, 32'd0);
      chk("rst_stall", {31'b0, stall_fetch}, 32'd0);
      chk("rst_done", {31'b0, fetch_done}, 32'd0);
      chk("rst_err", {31'b0, fetch_err}, 32'd0);
      chk_hold();
   endtask

   task automatic idle_jump(input logic [31:0] a);
      jump_en_ex   = 1'b1;
      jump_addr_ex = a;
      tick();
      jump_en_ex = 1'b0;
      m_pc  = {a[31:2], 2'b00};
      m_mis = a[1];
      chk("ij_addr", imem_bus.addr, m_pc);
      chk("ij_stall", {31'b0, stall_fetch}, 32'd0);
      chk("ij_done", {31'b0, fetch_done}, 32'd0);
      chk_hold();
   endtask

   // g: cycle of gnt (cycle 1 = first cycle after phase_fetch edge), r: rvalid delay
   // after gnt, j1/j2: redirect cycles (-1 none, j2 later), late: extra stray rvalid cycle
   task automatic fetch_txn(input int g, input int r, input int j1, input logic [31:0] a1,
                            input int j2, input logic [31:0] a2, input logic [31:0] rd,
                            input int late);
      int          c, last, lim, n;
      bit          ok;
      logic [31:0] opc, npc;
      opc  = m_pc;
      c    = g + r;
      ok   = (g <= TO) && (c <= TO);
      last = ok ? c : TO;
      lim  = (g < last) ? g : last;
      if (j2 >= 0)      npc = {a2[31:2], 2'b00};
      else if (j1 >= 0) npc = {a1[31:2], 2'b00};
      else              npc = ok ? opc + 32'd4 : opc;
      for (int k = 0; k <= last + 3; k++) begin
         phase_fetch     = (k == 0) || (k >= 1 && k <= last && $urandom_range(0, 3) == 0);
         jump_en_ex      = (k == j1) || (k == j2);
         jump_addr_ex    = (k == j2) ? a2 : ((k == j1) ? a1 : $urandom);
         imem_bus.gnt    = (k == g);
         imem_bus.rvalid = (k == c) || (k == late);
         imem_bus.rdata  = (k == c) ? rd : $urandom;
         tick();
         if (jump_en_ex) m_mis = jump_addr_ex[1];
         n = k + 1;
         if (n == last + 1) begin
            m_inst = ok ? rd : NOP;
            m_cur  = opc;
            m_nxt  = opc + 32'd4;
         end
         chk("req", {31'b0, imem_bus.req}, {31'b0, (n <= lim)});
         chk("stall", {31'b0, stall_fetch}, {31'b0, (n <= last)});
         chk("done", {31'b0, fetch_done}, {31'b0, (n == last + 1)});
         chk("err", {31'b0, fetch_err}, {31'b0, (n == last + 1) && !ok});
         chk("addr", imem_bus.addr, (n <= last) ? opc : npc);
         chk_hold();
      end
      clr_in();
      m_pc = npc;
   endtask

   initial begin
      #2000000;
      bad++;
      $display("FAIL sim_timeout: got running exp finished");
      $fatal(1, "simulation time limit");
   end

   initial begin
      rst = 1'b1;
      clr_in();
      do_reset();

      // zero-wait fetch from reset
      fetch_txn(1, 0, -1, 0, -1, 0, 32'h0050_0093, -1);
      chk("pc_after_first", imem_bus.addr, 32'h4);
      // gnt in cycle 1, rvalid in cycle 4
      fetch_txn(1, 3, -1, 0, -1, 0, $urandom, -1);
      // idle redirect with bit 1 set
      idle_jump(32'h0000_0102);
      chk("ij_target", imem_bus.addr, 32'h100);
      fetch_txn(1, 0, -1, 0, -1, 0, $urandom, -1);
      // redirect during WAIT, then a newer one in the rvalid cycle
      fetch_txn(1, 3, 2, 32'h200, -1, 0, $urandom, -1);
      chk("pend_200", imem_bus.addr, 32'h200);
      fetch_txn(1, 3, 2, 32'h200, 4, 32'h300, $urandom, -1);
      chk("pend_300", imem_bus.addr, 32'h300);
      // redirect together with phase_fetch
      fetch_txn(2, 1, 0, 32'h0000_0404, -1, 0, $urandom, -1);
      // watchdog abort with a late rvalid in cycle 7
      fetch_txn(99, 0, -1, 0, -1, 0, $urandom, 7);
      // abort with a pending redirect
      fetch_txn(2, 9, 3, 32'h0000_0808, -1, 0, $urandom, -1);
      // PC wraparound
      idle_jump(32'hFFFF_FFFC);
      fetch_txn(1, 0, -1, 0, -1, 0, $urandom, -1);
      chk("wrap_pc", imem_bus.addr, 32'h0);
      chk("wrap_next", next_pc_fd, 32'h0);

      // reset while waiting for rvalid
      phase_fetch = 1'b1;
      tick();
      phase_fetch  = 1'b0;
      imem_bus.gnt = 1'b1;
      tick();
      imem_bus.gnt = 1'b0;
      chk("wait_stall", {31'b0, stall_fetch}, 32'd1);
      chk("wait_req", {31'b0, imem_bus.req}, 32'd0);
      do_reset();
      imem_bus.rvalid = 1'b1;
      imem_bus.rdata  = 32'hDEAD_BEEF;
      tick();
      imem_bus.rvalid = 1'b0;
      chk("post_rst_done", {31'b0, fetch_done}, 32'd0);
      chk("post_rst_stall", {31'b0, stall_fetch}, 32'd0);
      chk("post_rst_addr", imem_bus.addr, 32'h0);
      chk_hold();

      for (int t = 0; t < 300; t++) begin
         int g, r, last, j1, j2;
         g    = $urandom_range(1, TO + 1);
         r    = $urandom_range(0, TO);
         last = ((g <= TO) && (g + r <= TO)) ? g + r : TO;
         j1   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, last)) : -1;
         j2   = (j1 >= 0 && j1 < last && $urandom_range(0, 1) == 1) ?
                int'($urandom_range(j1 + 1, last)) : -1;
         fetch_txn(g, r, j1, $urandom, j2, $urandom, $urandom, -1);
         if ($urandom_range(0, 5) == 0) idle_jump($urandom);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
